// File: rtl/tx_qpsk_framer_pkg.sv
// Shared types for the QPSK transmit framer.
// IQ sample bundle, framer states and sample width.
package tx_pkg;

  localparam int IQ_WIDTH = 12;

  typedef struct packed {
    logic signed [IQ_WIDTH-1:0] i;
    logic signed [IQ_WIDTH-1:0] q;
  } iq_sample_t;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    PAYLOAD,
    GAP
  } tx_state_t;

endpackage

// File: rtl/tx_qpsk_framer_mapper.sv
// QPSK sign mapper: dibit {b1,b0} -> {I,Q}, bit set = -AMP.
// Ports: dibit, zero (force I=Q=0), iq (mapped sample).
module qpsk_mapper
  import tx_pkg::*;
#(
  parameter logic signed [IQ_WIDTH-1:0] AMP = 12'sd1448
) (
  input  logic [1:0] dibit,
  input  logic       zero,
  output iq_sample_t iq
);

  localparam logic signed [IQ_WIDTH-1:0] NEG = -AMP;

  always_comb begin
    iq.i = dibit[1] ? NEG : AMP;
    iq.q = dibit[0] ? NEG : AMP;
    if (zero) iq = '0;
  end

endmodule

// File: rtl/tx_qpsk_framer.sv
// Byte stream -> framed (sync, payload, gap) QPSK sample stream.
// Ports: clk, rst, in_valid/in_ready/in_data, out_valid/out_ready/out_data, underrun.
module tx_qpsk_framer
  import tx_pkg::*;
#(
  parameter int unsigned                SPS         = 4,
  parameter logic signed [IQ_WIDTH-1:0] AMP         = 12'sd1448,
  parameter logic [31:0]                SYNC_WORD   = 32'h1ACFFC1D,
  parameter int unsigned                SYNC_BITS   = 32,
  parameter int unsigned                PAYLOAD_LEN = 16,
  parameter int unsigned                GAP_SYMBOLS = 8,
  parameter logic [7:0]                 FILL_BYTE   = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*IQ_WIDTH-1:0]   out_data,
  output logic                    underrun
);

  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0] S_LAST = CW'(SPS - 1);
  localparam logic [15:0] SYNC_SYMS = 16'(SYNC_BITS / 2);
  localparam logic [15:0] B_LAST = 16'(PAYLOAD_LEN - 1);
  localparam logic [15:0] G_LAST = 16'(GAP_SYMBOLS);
  // Sync word left-justified so dibit k sits at [31:30] after a 2k shift.
  localparam logic [31:0] SYNC_AL = SYNC_WORD << (32 - SYNC_BITS);

  tx_state_t       state, st_n;
  logic [CW-1:0]   scnt, scnt_n;
  logic [15:0]     sym, sym_n;
  logic [15:0]     bcnt, bcnt_n;
  logic [1:0]      dcnt, dcnt_n;
  logic [7:0]      sh, sh_n;
  logic [7:0]      hold;
  logic            hold_full;
  logic [7:0]      fbyte;
  logic [1:0]      dibit;
  logic            zero, load, drain, under;
  logic            fire, bnd, accept;
  iq_sample_t      map_iq;

  function automatic logic [1:0] sync_dibit(input logic [15:0] k);
    logic [31:0] w;
    w = SYNC_AL << {k, 1'b0};
    return w[31:30];
  endfunction

  assign in_ready = out_valid & ~hold_full;
  assign accept   = in_valid & in_ready;
  assign fire     = out_valid & out_ready;
  assign bnd      = fire & (scnt == S_LAST);
  assign fbyte    = hold_full ? hold : FILL_BYTE;

  qpsk_mapper #(.AMP(AMP)) u_map (
    .dibit (dibit),
    .zero  (zero),
    .iq    (map_iq)
  );

  always_comb begin
    st_n   = state;
    scnt_n = scnt;
    sym_n  = sym;
    bcnt_n = bcnt;
    dcnt_n = dcnt;
    sh_n   = sh;
    dibit  = 2'b00;
    zero   = 1'b1;
    load   = 1'b0;
    drain  = 1'b0;
    under  = 1'b0;
    if (fire) scnt_n = (scnt == S_LAST) ? '0 : scnt + 1'b1;
    if (bnd) begin
      load = 1'b1;
      unique case (state)
        IDLE: begin
          if (hold_full) begin
            st_n  = SYNC;
            zero  = 1'b0;
            dibit = sync_dibit(16'd0);
            sym_n = 16'd1;
          end
        end
        SYNC: begin
          zero = 1'b0;
          if (sym == SYNC_SYMS) begin
            st_n   = PAYLOAD;
            dibit  = fbyte[7:6];
            sh_n   = {fbyte[5:0], 2'b00};
            dcnt_n = 2'd0;
            bcnt_n = 16'd0;
            drain  = hold_full;
            under  = ~hold_full;
          end else begin
            dibit = sync_dibit(sym);
            sym_n = sym + 16'd1;
          end
        end
        PAYLOAD: begin
          if (dcnt != 2'd3) begin
            zero   = 1'b0;
            dibit  = sh[7:6];
            sh_n   = {sh[5:0], 2'b00};
            dcnt_n = dcnt + 2'd1;
          end else if (bcnt == B_LAST) begin
            sym_n = 16'd1;
            st_n  = (GAP_SYMBOLS > 0) ? GAP : IDLE;
          end else begin
            zero   = 1'b0;
            dibit  = fbyte[7:6];
            sh_n   = {fbyte[5:0], 2'b00};
            dcnt_n = 2'd0;
            bcnt_n = bcnt + 16'd1;
            drain  = hold_full;
            under  = ~hold_full;
          end
        end
        GAP: begin
          if (sym == G_LAST) st_n = IDLE;
          else               sym_n = sym + 16'd1;
        end
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scnt      <= '0;
      sym       <= '0;
      bcnt      <= '0;
      dcnt      <= '0;
      sh        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      underrun  <= 1'b0;
    end else begin
      state     <= st_n;
      scnt      <= scnt_n;
      sym       <= sym_n;
      bcnt      <= bcnt_n;
      dcnt      <= dcnt_n;
      sh        <= sh_n;
      out_valid <= 1'b1;
      underrun  <= under;
      if (load) out_data <= map_iq;
      if (accept) hold <= in_data;
      hold_full <= accept | (hold_full & ~drain);
    end
  end

endmodule
